icache_direct: RTL and testbench
================================

ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 Parameter INDEX_BITS, default 6, sets the line count to 2^INDEX_BITS with one 32-bit word per line.
REQ-002 clk  in  1  system clock, rising-edge; rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global ready; when low, every register holds its value.
REQ-004 fetch_valid  in  1  fetch unit requests the instruction at fetch_pc.
REQ-005 fetch_pc  in  32  byte address of the requested instruction, word-aligned.
REQ-006 flush  in  1  pipeline flush (branch redirect); the current request is void.
REQ-007 inst_valid  out  1  inst holds the word at fetch_pc this cycle.
REQ-008 inst  out  32  instruction word.
REQ-009 mem_req  out  1  read request to the memory controller, held high until mem_done.
REQ-010 mem_addr  out  32  word address of the line being filled, stable while mem_req is high.
REQ-011 mem_done  in  1  one-cycle pulse: mem_data is valid, transaction finished.
REQ-012 mem_data  in  32  little-endian word returned by memory.

Function
REQ-013 Address split: index = fetch_pc[INDEX_BITS+1:2]; tag = fetch_pc[31:INDEX_BITS+2]; bits [1:0] are ignored.
REQ-014 Storage: valid bit, tag array and data array, one entry per index; valid bits only are reset.
REQ-015 Hit = fetch_valid & valid[index] & (tag_arr[index] == tag); lookup is combinational.
REQ-016 inst_valid = hit & ~flush & (state == IDLE); inst = data_arr[index]; zero-cycle hit latency.
REQ-017 FSM states: IDLE, MISS, REFILL_DONE.
REQ-018 IDLE -> MISS when fetch_valid & ~hit & ~flush: latch {fetch_pc[31:2],2'b00} into mem_addr and set mem_req=1 on the same edge.
REQ-019 MISS: hold mem_req and mem_addr; on mem_done, write mem_data, tag and valid=1 at the latched index, clear mem_req, go to REFILL_DONE.
REQ-020 REFILL_DONE -> IDLE unconditionally after one cycle, so the refetch hits and arrays are never read and written in the same cycle.
REQ-021 mem_req is never asserted for two back-to-back transactions without at least one cycle low between them.
REQ-022 A flush during MISS does not abort the memory transaction; the fill completes and is installed, since instruction memory is read-only.
REQ-023 A fetch_pc change during MISS does not alter mem_addr; after REFILL_DONE the new pc is looked up afresh.
REQ-024 A fill to an index holding a valid line with another tag overwrites it (direct-mapped replacement).
REQ-025 mem_done arriving in IDLE or REFILL_DONE is ignored.
REQ-026 When rdy is low, state, arrays, mem_req and mem_addr hold; a mem_done pulse in that cycle is still captured into a pending flag and applied when rdy returns.

Reset
REQ-027 On rst: state=IDLE, all valid bits=0, mem_req=0, mem_addr=0, pending flag=0; inst_valid=0 follows combinationally.
REQ-028 rst during MISS abandons the transaction; a later mem_done for it is ignored per REQ-025.

Structure
REQ-029 State encodings, the INDEX_BITS default and the word width belong in the shared constants package next to the existing bus-width macros.
REQ-030 No sub-module; arrays are plain register arrays inside icache_direct.

Verification
REQ-031 After rst, fetch_pc=0x0000_0000, fetch_valid=1 -> mem_req=1, mem_addr=0x0 next cycle; mem_done with data 0x0000_0013 -> inst_valid=1, inst=0x0000_0013 two cycles later.
REQ-032 Repeat fetch 0x0 -> inst_valid=1 in the same cycle; mem_req stays 0.
REQ-033 Conflict: fill 0x100 (index 0, tag 1) with 0xDEAD_BEEF, then fetch 0x0 -> miss, new request at 0x0; then fetch 0x100 -> miss again.
REQ-034 flush=1 while in MISS for 0x40 -> mem_req held, fill completes, later fetch 0x40 hits with no new request.
REQ-035 rdy=0 for 3 cycles spanning mem_done -> no state change while low; the line is installed after rdy=1.
REQ-036 rst asserted mid-MISS -> mem_req=0 next cycle; a stray mem_done is ignored and 0x0 still misses.

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared constants for the direct-mapped instruction cache: word width,
// default geometry and the refill FSM encoding.
package icache_direct_pkg;

   localparam int unsigned WORD_W            = 32;
   localparam int unsigned ICACHE_INDEX_BITS = 6;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      MISS        = 2'd1,
      REFILL_DONE = 2'd2
   } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one word per line, zero-cycle hit path and
// a single outstanding refill request to the memory controller.
module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   input  logic        flush,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);

   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = WORD_W - INDEX_BITS - 2;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_arr  [LINES];
   logic [WORD_W-1:0]   data_arr [LINES];

   icache_state_t state_q, state_d;

   logic                  pend_q;
   logic [WORD_W-1:0]     pend_data_q;
   logic [INDEX_BITS-1:0] index, fill_index;
   logic [TAG_BITS-1:0]   tag, fill_tag;
   logic                  hit, done_eff, start_miss, fill_we;
   logic [WORD_W-1:0]     fill_data;
   logic                  pc_byte_unused;

   assign index          = fetch_pc[INDEX_BITS+1:2];
   assign tag            = fetch_pc[31:INDEX_BITS+2];
   assign fill_index     = mem_addr[INDEX_BITS+1:2];
   assign fill_tag       = mem_addr[31:INDEX_BITS+2];
   assign pc_byte_unused = ^fetch_pc[1:0];

   assign hit = fetch_valid & valid_q[index] & (tag_arr[index] == tag);

   // A mem_done seen while stalled is replayed from the pending flag/data.
   assign done_eff  = mem_done | pend_q;
   assign fill_data = pend_q ? pend_data_q : mem_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (rdy) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (fetch_valid && !hit && !flush) state_d = MISS;
         MISS:        if (done_eff) state_d = REFILL_DONE;
         REFILL_DONE: state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      inst_valid = hit & ~flush & (state_q == IDLE);
      inst       = data_arr[index];
      start_miss = (state_q == IDLE) & fetch_valid & ~hit & ~flush;
      fill_we    = (state_q == MISS) & done_eff;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         valid_q     <= '0;
      end else if (rdy) begin
         pend_q <= 1'b0;
         if (start_miss) begin
            mem_req  <= 1'b1;
            mem_addr <= {fetch_pc[31:2], 2'b00};
         end
         if (fill_we) begin
            mem_req             <= 1'b0;
            valid_q[fill_index] <= 1'b1;
         end
      end else if (mem_done && state_q == MISS) begin
         pend_q      <= 1'b1;
         pend_data_q <= mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && fill_we) begin
         tag_arr[fill_index]  <= fill_tag;
         data_arr[fill_index] <= fill_data;
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: expectations are queued as stimulus is
// driven and compared at the following falling clock edge.
module tb_icache_direct;

   logic        clk = 1'b0;
   logic        rst, rdy, fetch_valid, flush, mem_done;
   logic [31:0] fetch_pc, mem_data;
   logic        inst_valid, mem_req;
   logic [31:0] inst, mem_addr;

   int tests = 0;
   int fails = 0;

   localparam int K_IV   = 0;
   localparam int K_INST = 1;
   localparam int K_REQ  = 2;
   localparam int K_ADDR = 3;

   string       q_name [$];
   int          q_kind [$];
   logic [31:0] q_val  [$];

   always #5 clk = ~clk;

   icache_direct #(.INDEX_BITS(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .flush       (flush),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_done    (mem_done),
      .mem_data    (mem_data)
   );

   task automatic expect_out(input string n, input int k, input logic [31:0] v);
      q_name.push_back(n);
      q_kind.push_back(k);
      q_val.push_back(v);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk();
      string       n;
      int          k;
      logic [31:0] v, obs;
      @(negedge clk);
      while (q_name.size() != 0) begin
         n = q_name.pop_front();
         k = q_kind.pop_front();
         v = q_val.pop_front();
         case (k)
            K_IV:    obs = {31'b0, inst_valid};
            K_INST:  obs = inst;
            K_REQ:   obs = {31'b0, mem_req};
            default: obs = mem_addr;
         endcase
         tests++;
         assert (obs === v) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", n, obs, v);
         end
      end
   endtask

   task automatic fill(input string p, input logic [31:0] pc, input logic [31:0] d);
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      flush       = 1'b0;
      expect_out({p, "_miss_iv"}, K_IV, 32'd0);
      chk(); cyc();
      expect_out({p, "_req"}, K_REQ, 32'd1);
      expect_out({p, "_addr"}, K_ADDR, {pc[31:2], 2'b00});
      chk();
      mem_done = 1'b1;
      mem_data = d;
      cyc();
      mem_done = 1'b0;
      expect_out({p, "_rd_req"}, K_REQ, 32'd0);
      expect_out({p, "_rd_iv"}, K_IV, 32'd0);
      chk(); cyc();
      expect_out({p, "_hit_iv"}, K_IV, 32'd1);
      expect_out({p, "_hit_inst"}, K_INST, d);
      expect_out({p, "_hit_req"}, K_REQ, 32'd0);
      chk(); cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h0;
      flush = 1'b0; mem_done = 1'b0; mem_data = 32'h0;
      cyc(); cyc();
      expect_out("rst_iv", K_IV, 32'd0);
      expect_out("rst_req", K_REQ, 32'd0);
      expect_out("rst_addr", K_ADDR, 32'h0);
      chk(); cyc();
      rst = 1'b0;

      // first fill and repeat hit
      fill("f0", 32'h0000_0000, 32'h0000_0013);
      expect_out("rep_iv", K_IV, 32'd1);
      expect_out("rep_inst", K_INST, 32'h0000_0013);
      expect_out("rep_req", K_REQ, 32'd0);
      chk(); cyc();
      fetch_valid = 1'b0;
      expect_out("nofetch_iv", K_IV, 32'd0);
      expect_out("nofetch_req", K_REQ, 32'd0);
      chk(); cyc();

      // conflict in index 0
      fill("c100", 32'h0000_0100, 32'hDEAD_BEEF);
      fill("c000", 32'h0000_0000, 32'h0000_0013);
      fill("c100b", 32'h0000_0100, 32'hDEAD_BEEF);

      // flush in IDLE suppresses hit and miss
      fetch_valid = 1'b1; fetch_pc = 32'h100; flush = 1'b1;
      expect_out("flh_hit_iv", K_IV, 32'd0);
      chk(); cyc();
      fetch_pc = 32'h80;
      expect_out("flh_req", K_REQ, 32'd0);
      chk(); cyc();
      expect_out("flm_req", K_REQ, 32'd0);
      flush = 1'b0; fetch_valid = 1'b0;
      chk(); cyc();

      // flush and pc change during MISS
      fetch_valid = 1'b1; fetch_pc = 32'h40;
      expect_out("fm_miss_iv", K_IV, 32'd0);
      chk(); cyc();
      flush = 1'b1; fetch_pc = 32'h44;
      expect_out("fm_req", K_REQ, 32'd1);
      expect_out("fm_addr", K_ADDR, 32'h40);
      chk(); cyc();
      expect_out("fm_req2", K_REQ, 32'd1);
      expect_out("fm_addr2", K_ADDR, 32'h40);
      chk();
      mem_done = 1'b1; mem_data = 32'h1234_5678;
      cyc();
      mem_done = 1'b0; flush = 1'b0; fetch_pc = 32'h40;
      expect_out("fm_rd_req", K_REQ, 32'd0);
      chk(); cyc();
      expect_out("fm_hit_iv", K_IV, 32'd1);
      expect_out("fm_hit_inst", K_INST, 32'h1234_5678);
      chk(); cyc();
      expect_out("fm_noreq", K_REQ, 32'd0);
      chk(); cyc();

      // rdy low across mem_done
      fetch_pc = 32'hC0;
      expect_out("rdy_miss_iv", K_IV, 32'd0);
      chk(); cyc();
      rdy = 1'b0;
      expect_out("rdy_req", K_REQ, 32'd1);
      expect_out("rdy_addr", K_ADDR, 32'hC0);
      chk(); cyc();
      mem_done = 1'b1; mem_data = 32'hCAFE_F00D;
      expect_out("rdy_req1", K_REQ, 32'd1);
      chk(); cyc();
      mem_done = 1'b0;
      expect_out("rdy_req2", K_REQ, 32'd1);
      expect_out("rdy_iv2", K_IV, 32'd0);
      chk(); cyc();
      rdy = 1'b1;
      expect_out("rdy_req3", K_REQ, 32'd1);
      expect_out("rdy_addr3", K_ADDR, 32'hC0);
      chk(); cyc();
      expect_out("rdy_rd_req", K_REQ, 32'd0);
      expect_out("rdy_rd_iv", K_IV, 32'd0);
      chk(); cyc();
      expect_out("rdy_hit_iv", K_IV, 32'd1);
      expect_out("rdy_hit_inst", K_INST, 32'hCAFE_F00D);
      chk(); cyc();

      // reset mid-MISS, stray mem_done afterwards
      fetch_pc = 32'h200;
      expect_out("rm_miss_iv", K_IV, 32'd0);
      chk(); cyc();
      expect_out("rm_req", K_REQ, 32'd1);
      expect_out("rm_addr", K_ADDR, 32'h200);
      chk();
      rst = 1'b1;
      cyc();
      rst = 1'b0; fetch_valid = 1'b0;
      expect_out("rm_rst_req", K_REQ, 32'd0);
      expect_out("rm_rst_addr", K_ADDR, 32'h0);
      chk();
      mem_done = 1'b1; mem_data = 32'hBAD0_BAD0;
      cyc();
      mem_done = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h0;
      expect_out("rm_stray_req", K_REQ, 32'd0);
      expect_out("rm_iv0", K_IV, 32'd0);
      chk(); cyc();
      expect_out("rm_req0", K_REQ, 32'd1);
      expect_out("rm_addr0", K_ADDR, 32'h0);
      chk(); cyc();
      expect_out("rm_req0_held", K_REQ, 32'd1);
      chk();
      mem_done = 1'b1; mem_data = 32'h0000_0013;
      cyc();
      mem_done = 1'b0;
      expect_out("rm_rd_req", K_REQ, 32'd0);
      chk(); cyc();
      expect_out("rm_hit_iv", K_IV, 32'd1);
      expect_out("rm_hit_inst", K_INST, 32'h0000_0013);
      chk(); cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
